// File: rtl/spi_master_nslave_if.sv
// Bus bundle between the control logic, the SPI master and the slave array.
// Use the master modport for the SPI master itself and the slave modport for the control/slave-array side.
interface spi_master_nslave_if #(
   parameter int DATA_W     = 16,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_W      = 2
);
   // Handshake: start is a request that is accepted only while the master is
   // idle and not pulsing done; busy rises the cycle after acceptance, done
   // pulses once at completion, and err pulses instead of busy when slave_sel
   // names a non-existent slave. A start that is not accepted is dropped.
   logic                  start;
   logic [SEL_W-1:0]      slave_sel;
   logic                  cpol;
   logic                  cpha;
   logic [DATA_W-1:0]     tx_data;
   logic                  MISO;
   logic                  SCLK;
   logic                  MOSI;
   logic [NUM_SLAVES-1:0] CS_N;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [DATA_W-1:0]     rx_data;
   logic [1:0]            dbg_state;

   modport master (
      input  start, slave_sel, cpol, cpha, tx_data, MISO,
      output SCLK, MOSI, CS_N, busy, done, err, rx_data, dbg_state
   );

   modport slave (
      output start, slave_sel, cpol, cpha, tx_data, MISO,
      input  SCLK, MOSI, CS_N, busy, done, err, rx_data, dbg_state
   );
endinterface

// File: rtl/spi_master_nslave.sv
// SPI master with NUM_SLAVES chip selects, runtime CPOL/CPHA and a CLK_DIV-derived SCLK.
// One DATA_W-bit word is exchanged MSB first per accepted start.
module spi_master_nslave #(
   parameter int DATA_W     = 16,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_W      = 2,
   parameter int CLK_DIV    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   spi_master_nslave_if.master  bus
);
   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HALF_W = $clog2(2 * DATA_W);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [HALF_W-1:0]     half_q, half_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic [DATA_W-1:0]     tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0]     rx_sr_q, rx_sr_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic [NUM_SLAVES-1:0] cs_n_q, cs_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [DATA_W-1:0]     rx_data_q, rx_data_d;

   logic period_end;
   logic leading;
   logic last_half;
   logic sample_en;
   logic shift_en;
   logic sel_ok;

   assign period_end = (cnt_q == CNT_LAST);
   // half_q counts SCLK toggles already made; an even count means the next toggle is a leading edge.
   assign leading    = ~half_q[0];
   assign last_half  = (half_q == HALF_LAST);
   assign sample_en  = cpha_q ? ~leading : leading;
   assign shift_en   = cpha_q ? leading : (~leading & ~last_half);
   assign sel_ok     = ({1'b0, bus.slave_sel} < (SEL_W + 1)'(NUM_SLAVES));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rx_data_d = rx_data_q;

      case (state_q)
         IDLE: begin
            sclk_d = cpol_q;
            // The done cycle is excluded so a start held across completion is not re-accepted.
            if (bus.start && !done_q) begin
               if (sel_ok) begin
                  state_d = SETUP;
                  cnt_d   = '0;
                  half_d  = '0;
                  cpol_d  = bus.cpol;
                  cpha_d  = bus.cpha;
                  sclk_d  = bus.cpol;
                  cs_n_d  = ~(NUM_SLAVES'(1) << bus.slave_sel);
                  busy_d  = 1'b1;
                  rx_sr_d = '0;
                  if (!bus.cpha) begin
                     mosi_d  = bus.tx_data[DATA_W-1];
                     tx_sr_d = bus.tx_data << 1;
                  end else begin
                     mosi_d  = 1'b0;
                     tx_sr_d = bus.tx_data;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SETUP: begin
            if (period_end) begin
               cnt_d   = '0;
               state_d = XFER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         XFER: begin
            if (period_end) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               half_d = half_q + HALF_W'(1);
               if (sample_en) rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.MISO};
               if (shift_en) begin
                  mosi_d  = tx_sr_q[DATA_W-1];
                  tx_sr_d = tx_sr_q << 1;
               end
               if (last_half) begin
                  half_d  = '0;
                  state_d = HOLD;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (period_end) begin
               cnt_d     = '0;
               state_d   = IDLE;
               cs_n_d    = '1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sr_q;
               mosi_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         half_q    <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign bus.SCLK      = sclk_q;
   assign bus.MOSI      = mosi_q;
   assign bus.CS_N      = cs_n_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.dbg_state = state_q;
endmodule
